// File: rtl/semseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : semseg_pkg
// Description : Register map, digit stride and FSM state type shared by the
//               seven-segment display controller.
// Revision    : 1.0 - initial release
// ============================================================================
package semseg_pkg;

    localparam logic [31:0] c_off_dig    = 32'h0000_0000;
    localparam logic [31:0] c_off_sel    = 32'h0000_0020;
    localparam logic [31:0] c_off_strb   = 32'h0000_0024;
    localparam logic [31:0] c_off_clr    = 32'h0000_0028;
    localparam logic [31:0] c_dig_stride = 32'd4;

    // Strobe register value meaning "no digit blinks".
    localparam logic [31:0] c_strb_none  = 32'h0000_00FF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_DIG  = 3'd2,
        S_SEL  = 3'd3,
        S_STRB = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/semseg_lzb.sv
`default_nettype none
// ============================================================================
// Module      : semseg_lzb
// Description : Leading-zero blank mask for eight hex digits; digit 0 is never
//               blanked. Built only when SEMSEG_CTRL_BLANK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef SEMSEG_CTRL_BLANK_EN
module semseg_lzb (
    input  logic [31:0] i_val,
    output logic [7:0]  o_mask
);

    assign o_mask[0] = 1'b1;

    // A digit stays lit when it or any more significant digit is non-zero.
    for (genvar i = 1; i < 8; i++) begin : g_dig
        assign o_mask[i] = |i_val[31:4*i];
    end

endmodule
`endif
`default_nettype wire

// File: rtl/semseg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : semseg_ctrl
// Description : Sequences one display request into register-bus writes:
//               clear, eight digits, select mask, strobe. Define
//               SEMSEG_CTRL_BLANK_EN to blank leading zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
module semseg_ctrl
    import semseg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned WAIT_CYC  = 0
) (
    input  logic        CLK100,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] val_i,
    input  logic [7:0]  mask_i,
    input  logic        strb_en_i,
    input  logic [2:0]  strb_idx_i,
    output logic        done_o,
    output logic        req_o,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] wdata_o
);

    localparam logic [3:0] c_wait = 4'(WAIT_CYC);

    state_t      r_state;
    logic [2:0]  r_idx;
    logic [3:0]  r_wait;
    logic [31:0] r_val;
    logic [7:0]  r_mask;
    logic        r_strb_en;
    logic [2:0]  r_strb_idx;

    state_t      w_state_nxt;
    logic [2:0]  w_idx_nxt;
    logic [3:0]  w_wait_nxt;
    logic        w_accept;
    logic        w_wait_done;
    logic [7:0]  w_sel_mask;
    logic [3:0]  w_digit;
    logic [31:0] w_strb_data;

`ifdef SEMSEG_CTRL_BLANK_EN
    logic [7:0]  w_lzb_mask;

    semseg_lzb u_lzb (
        .i_val  (r_val),
        .o_mask (w_lzb_mask)
    );

    assign w_sel_mask = r_mask & w_lzb_mask;
`else
    assign w_sel_mask = r_mask;
`endif

    assign w_accept    = valid_i && (r_state == S_IDLE);
    assign w_wait_done = (r_wait == c_wait);
    assign w_digit     = r_val[{r_idx, 2'b00} +: 4];
    assign w_strb_data = r_strb_en ? {29'h0, r_strb_idx} : c_strb_none;

    always_ff @(posedge CLK100) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_wait     <= '0;
            r_val      <= '0;
            r_mask     <= '0;
            r_strb_en  <= 1'b0;
            r_strb_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_wait  <= w_wait_nxt;
            if (w_accept) begin
                r_val      <= val_i;
                r_mask     <= mask_i;
                r_strb_en  <= strb_en_i;
                r_strb_idx <= strb_idx_i;
            end
        end
    end

    // Every write after CLR is preceded by WAIT_CYC idle cycles counted in r_wait.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_wait_nxt  = r_wait;
        ready_o     = 1'b0;
        done_o      = 1'b0;
        req_o       = 1'b0;
        we_o        = 1'b0;
        addr_o      = '0;
        wdata_o     = '0;

        case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_state_nxt = S_CLR;
                end
            end

            S_CLR: begin
                req_o       = 1'b1;
                we_o        = 1'b1;
                addr_o      = BASE_ADDR + c_off_clr;
                w_idx_nxt   = '0;
                w_wait_nxt  = '0;
                w_state_nxt = S_DIG;
            end

            S_DIG: begin
                if (!w_wait_done) begin
                    w_wait_nxt = r_wait + 4'd1;
                end else begin
                    req_o      = 1'b1;
                    we_o       = 1'b1;
                    addr_o     = BASE_ADDR + c_off_dig + (32'(r_idx) * c_dig_stride);
                    wdata_o    = {28'h0, w_digit};
                    w_wait_nxt = '0;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_SEL;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end
            end

            S_SEL: begin
                if (!w_wait_done) begin
                    w_wait_nxt = r_wait + 4'd1;
                end else begin
                    req_o       = 1'b1;
                    we_o        = 1'b1;
                    addr_o      = BASE_ADDR + c_off_sel;
                    wdata_o     = {24'h0, w_sel_mask};
                    w_wait_nxt  = '0;
                    w_state_nxt = S_STRB;
                end
            end

            S_STRB: begin
                if (!w_wait_done) begin
                    w_wait_nxt = r_wait + 4'd1;
                end else begin
                    req_o       = 1'b1;
                    we_o        = 1'b1;
                    addr_o      = BASE_ADDR + c_off_strb;
                    wdata_o     = w_strb_data;
                    w_wait_nxt  = '0;
                    w_state_nxt = S_DONE;
                end
            end

            S_DONE: begin
                done_o      = 1'b1;
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_semseg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_semseg_ctrl
// Description : Self-checking bench for semseg_ctrl; two instances (no wait,
//               two wait cycles with a non-zero base) against a write-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_semseg_ctrl;

    localparam logic [31:0] c_base0 = 32'h0000_0000;
    localparam logic [31:0] c_base1 = 32'h4000_1000;
`ifdef SEMSEG_CTRL_BLANK_EN
    localparam bit c_blank_en = 1'b1;
`else
    localparam bit c_blank_en = 1'b0;
`endif

    logic        CLK100;
    logic        rst      [2];
    logic        valid    [2];
    logic        ready    [2];
    logic [31:0] val      [2];
    logic [7:0]  mask     [2];
    logic        strb_en  [2];
    logic [2:0]  strb_idx [2];
    logic        done     [2];
    logic        req      [2];
    logic        we       [2];
    logic [31:0] addr     [2];
    logic [31:0] wdata    [2];

    int checks = 0;
    int errors = 0;
    int cur_d  = 0;

    semseg_ctrl #(.BASE_ADDR(c_base0), .WAIT_CYC(0)) u_dut0 (
        .CLK100(CLK100), .reset(rst[0]), .valid_i(valid[0]), .ready_o(ready[0]),
        .val_i(val[0]), .mask_i(mask[0]), .strb_en_i(strb_en[0]), .strb_idx_i(strb_idx[0]),
        .done_o(done[0]), .req_o(req[0]), .we_o(we[0]), .addr_o(addr[0]), .wdata_o(wdata[0])
    );

    semseg_ctrl #(.BASE_ADDR(c_base1), .WAIT_CYC(2)) u_dut1 (
        .CLK100(CLK100), .reset(rst[1]), .valid_i(valid[1]), .ready_o(ready[1]),
        .val_i(val[1]), .mask_i(mask[1]), .strb_en_i(strb_en[1]), .strb_idx_i(strb_idx[1]),
        .done_o(done[1]), .req_o(req[1]), .we_o(we[1]), .addr_o(addr[1]), .wdata_o(wdata[1])
    );

    initial CLK100 = 1'b0;
    always #5 CLK100 = ~CLK100;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, cur_d, obs, exp);
        end
    endtask

    // Select mask from the digit values: keep digits up to the highest non-zero one.
    function automatic logic [7:0] model_sel(input logic [31:0] v, input logic [7:0] m);
        int top;
        int keep;
        top = 0;
        for (int i = 0; i < 8; i++) begin
            if (((v >> (4 * i)) & 32'hF) != 32'h0) top = i;
        end
        keep = (1 << (top + 1)) - 1;
        return c_blank_en ? (m & 8'(keep)) : m;
    endfunction

    task automatic chk_quiet(input string tag, input int d);
        chk({tag, "_req"},   32'(req[d]),   32'h0);
        chk({tag, "_we"},    32'(we[d]),    32'h0);
        chk({tag, "_addr"},  addr[d],       32'h0);
        chk({tag, "_wdata"}, wdata[d],      32'h0);
        chk({tag, "_done"},  32'(done[d]),  32'h0);
        chk({tag, "_ready"}, 32'(ready[d]), 32'h1);
    endtask

    task automatic txn(input int d, input logic [31:0] v, input logic [7:0] m,
                       input logic se, input logic [2:0] si, input bit hold, input int abort_j);
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic [31:0] base;
        int n, cyc, wr;
        bit fin;
        cur_d = d;
        n     = (d == 0) ? 0 : 2;
        base  = (d == 0) ? c_base0 : c_base1;
        ea.push_back(base + 32'h28); ed.push_back(32'h0);
        for (int i = 0; i < 8; i++) begin
            ea.push_back(base + 32'(4 * i));
            ed.push_back((v >> (4 * i)) & 32'hF);
        end
        ea.push_back(base + 32'h20); ed.push_back({24'h0, model_sel(v, m)});
        ea.push_back(base + 32'h24); ed.push_back(se ? {29'h0, si} : 32'h0000_00FF);

        @(negedge CLK100);
        chk("ready_before_req", 32'(ready[d]), 32'h1);
        valid[d] = 1'b1; val[d] = v; mask[d] = m; strb_en[d] = se; strb_idx[d] = si;
        cyc = 0; wr = 0; fin = 1'b0;
        while (!fin) begin
            @(negedge CLK100);
            cyc++;
            valid[d]    = hold;
            val[d]      = $urandom;
            mask[d]     = 8'($urandom);
            strb_en[d]  = 1'($urandom);
            strb_idx[d] = 3'($urandom);
            if (cyc > 200) begin
                chk("timeout_no_done", 32'h0, 32'h1);
                fin = 1'b1;
            end else if (req[d]) begin
                chk("we_with_req", 32'(we[d]), 32'h1);
                chk("ready_busy", 32'(ready[d]), 32'h0);
                chk("write_cycle", 32'(cyc), 32'((wr == 0) ? 1 : 1 + wr * (n + 1)));
                if (wr < 11) begin
                    chk("write_addr", addr[d], ea[wr]);
                    chk("write_data", wdata[d], ed[wr]);
                end else begin
                    chk("extra_write", 32'(wr), 32'd10);
                end
                if (wr == abort_j) begin
                    rst[d] = 1'b1;
                    @(negedge CLK100);
                    chk_quiet("after_abort", d);
                    rst[d] = 1'b0;
                    repeat (4) begin
                        @(negedge CLK100);
                        chk_quiet("post_abort", d);
                    end
                    fin = 1'b1;
                end
                wr++;
            end else begin
                chk("idle_we", 32'(we[d]), 32'h0);
                chk("idle_addr", addr[d], 32'h0);
                chk("idle_wdata", wdata[d], 32'h0);
                if (done[d]) begin
                    chk("done_cycle", 32'(cyc), 32'(12 + 10 * n));
                    chk("write_count", 32'(wr), 32'd11);
                    fin = 1'b1;
                end
            end
        end
        if (!hold) valid[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b1; val[d] = 32'hDEAD_BEEF;
            mask[d] = 8'hFF; strb_en[d] = 1'b1; strb_idx[d] = 3'd3;
        end
        repeat (3) @(negedge CLK100);
        for (int d = 0; d < 2; d++) begin
            cur_d = d;
            chk_quiet("in_reset", d);
            rst[d] = 1'b0; valid[d] = 1'b0;
        end
        repeat (3) begin
            @(negedge CLK100);
            for (int d = 0; d < 2; d++) begin
                cur_d = d;
                chk_quiet("after_reset", d);
            end
        end

        for (int d = 0; d < 2; d++) begin
            txn(d, 32'h1234_ABCD, 8'hFF, 1'b0, 3'd0, 1'b0, -1);
            txn(d, 32'h8765_4321, 8'hA5, 1'b1, 3'd5, 1'b0, -1);
            txn(d, 32'h0000_0042, 8'hFF, 1'b0, 3'd0, 1'b0, -1);
            txn(d, 32'h0000_0000, 8'hFF, 1'b1, 3'd7, 1'b0, -1);
            txn(d, 32'h0F00_0000, 8'h7E, 1'b1, 3'd0, 1'b0, -1);
            txn(d, $urandom, 8'($urandom), 1'b1, 3'($urandom), 1'b0, 4);
            txn(d, 32'hCAFE_F00D, 8'hFF, 1'b0, 3'd0, 1'b0, -1);
            txn(d, $urandom, 8'($urandom), 1'($urandom), 3'($urandom), 1'b1, -1);
            txn(d, 32'h0000_9ABC, 8'hFF, 1'b1, 3'd2, 1'b0, -1);
            repeat (4) txn(d, $urandom >> (4 * $urandom_range(0, 7)), 8'($urandom),
                           1'($urandom), 3'($urandom), 1'b0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/semseg_ctrl.md
SEMSEG_CTRL -- requirements
Module: semseg_ctrl

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, base address of the seven-segment register block.
REQ-002 Parameter WAIT_CYC, 0, idle cycles with req_o=0 inserted between consecutive writes (0..15).
REQ-003 CLK100  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 valid_i  in  1  new display request.
REQ-006 ready_o  out  1  controller idle, request accepted when valid_i&&ready_o.
REQ-007 val_i  in  32  eight hex digits; digit i = val_i[4i+3:4i].
REQ-008 mask_i  in  8  digit enable mask; bit i enables digit i.
REQ-009 strb_en_i  in  1  enable blinking of one digit.
REQ-010 strb_idx_i  in  3  index of the blinking digit.
REQ-011 done_o  out  1  one-cycle pulse after the last write.
REQ-012 req_o, we_o  out  1 each  register-bus request and write strobe.
REQ-013 addr_o, wdata_o  out  32 each  register-bus address and write data.

Function
REQ-014 On acceptance, val_i, mask_i, strb_en_i and strb_idx_i SHALL be captured; later input changes have no effect until the next acceptance.
REQ-015 FSM states: IDLE, CLR, DIG, SEL, STRB, DONE; ready_o=1 only in IDLE.
REQ-016 IDLE->CLR on acceptance; CLR->DIG; DIG repeats for idx 0..7 then ->SEL; SEL->STRB; STRB->DONE; DONE->IDLE after one cycle.
REQ-017 CLR write: addr BASE_ADDR+0x28, wdata 0.
REQ-018 DIG write idx i: addr BASE_ADDR+4*i, wdata {28'h0, digit i}.
REQ-019 SEL write: addr BASE_ADDR+0x20, wdata {24'h0, sel_mask}.
REQ-020 STRB write: addr BASE_ADDR+0x24, wdata {29'h0, strb_idx} if strb_en captured, else 32'h0000_00FF.
REQ-021 Every write SHALL last exactly one cycle with req_o=we_o=1; outside a write cycle req_o=we_o=0, addr_o=wdata_o=0.
REQ-022 With WAIT_CYC=0: acceptance at cycle 0, writes on cycles 1..11 in order CLR, DIG0..DIG7, SEL, STRB, done_o=1 on cycle 12, ready_o=1 again on cycle 13.
REQ-023 With WAIT_CYC=N: N idle cycles precede each write after CLR; total latency to done_o = 12+10N cycles.
REQ-024 valid_i while ready_o=0 SHALL be ignored (no queuing).
REQ-025 Wait counter and digit index SHALL not wrap; digit index terminates at 7.

Reset
REQ-026 reset SHALL force IDLE, ready_o=1, done_o=0, req_o=we_o=0, addr_o=wdata_o=0, clear captured registers and counters.
REQ-027 reset asserted mid-sequence SHALL abort it in the same edge; no further write is issued and done_o is not pulsed.
REQ-028 valid_i while reset=1 SHALL not be accepted.

Configuration
REQ-029 Macro SEMSEG_CTRL_BLANK_EN defined: sel_mask = mask_i with leading-zero digits cleared (highest digits equal to 0 down to, not including, the highest non-zero digit; digit 0 never blanked).
REQ-030 Macro undefined: sel_mask = captured mask_i unmodified.

Structure
REQ-031 Package semseg_pkg SHALL hold the register offsets (0x00, 0x20, 0x24, 0x28), the digit stride 4 and the FSM state typedef.
REQ-032 Sub-module semseg_lzb SHALL compute the leading-zero blank mask (combinational, 32-bit value in, 8-bit mask out); instantiated only under SEMSEG_CTRL_BLANK_EN.

Verification
REQ-033 val_i=32'h1234_ABCD, mask_i=FF, strb_en_i=0, WAIT_CYC=0 -> writes 0x28:0, 0x00:D,0x04:C,0x08:B,0x0C:A,0x10:4,0x14:3,0x18:2,0x1C:1, 0x20:FF, 0x24:FF; done_o on cycle 12.
REQ-034 strb_en_i=1, strb_idx_i=5 -> STRB write 0x24:0000_0005.
REQ-035 BLANK_EN, val_i=32'h0000_0042, mask_i=FF -> SEL write 0x20:03; without macro -> 0x20:FF; val_i=0 with macro -> 0x20:01.
REQ-036 WAIT_CYC=2 -> two req_o=0 cycles between consecutive writes, done_o on cycle 32.
REQ-037 reset asserted during DIG3 -> no further req_o, ready_o=1 next cycle, no done_o; subsequent request completes normally.
REQ-038 valid_i held high during busy with different val_i -> only first value written; second accepted only after ready_o returns.
